// File: rtl/mem_arbiter.sv
// Two-master (fetch / data) arbiter onto a single-outstanding memory port.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin on collisions; default is D-priority.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_req,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  output logic                    i_gnt,
  output logic                    i_rvalid,
  output logic [DATA_WIDTH-1:0]   i_rdata,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_be,
  output logic                    d_gnt,
  output logic                    d_rvalid,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    m_req,
  output logic                    m_we,
  output logic [ADDR_WIDTH-1:0]   m_addr,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_be,
  input  logic                    m_ack,
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  output logic                    busy
);

  localparam int BE_W = DATA_WIDTH / 8;
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    RESP
  } state_t;

  state_t state;
  state_t state_n;

  logic                  last_owner;
  logic                  pick_d;
  logic                  start;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [BE_W-1:0]       be_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  assign start = i_req | d_req;

  // pick_d is only ever set while d_req is high
  always_comb begin
    pick_d = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    if (i_req && d_req) begin
      pick_d = (last_owner == OWN_I);
    end else begin
      pick_d = d_req;
    end
`else
    pick_d = d_req;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = pick_d ? BUSY_D : BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (m_ack) begin
          state_n = RESP;
        end
      end
      RESP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    i_gnt    = 1'b0;
    d_gnt    = 1'b0;
    m_req    = 1'b0;
    i_rvalid = 1'b0;
    d_rvalid = 1'b0;
    unique case (state)
      IDLE: begin
        i_gnt = i_req & ~pick_d & ~reset;
        d_gnt = pick_d & ~reset;
      end
      BUSY_I, BUSY_D: m_req = 1'b1;
      RESP: begin
        i_rvalid = (last_owner == OWN_I);
        d_rvalid = (last_owner == OWN_D);
      end
      default: ;
    endcase
  end

  // Fetches are latched as full-word reads so the memory side needs no owner
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_owner <= OWN_I;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      be_q       <= '0;
      rdata_q    <= '0;
    end else begin
      if (state == IDLE && start) begin
        last_owner <= pick_d ? OWN_D : OWN_I;
        addr_q     <= pick_d ? d_addr : i_addr;
        we_q       <= pick_d & d_we;
        wdata_q    <= pick_d ? d_wdata : '0;
        be_q       <= pick_d ? d_be : '1;
      end
      if ((state == BUSY_I || state == BUSY_D) && m_ack) begin
        rdata_q <= m_rdata;
      end
    end
  end

  assign m_we    = m_req & we_q;
  assign m_addr  = m_req ? addr_q : '0;
  assign m_wdata = m_req ? wdata_q : '0;
  assign m_be    = m_req ? be_q : '0;
  assign i_rdata = rdata_q;
  assign d_rdata = we_q ? '0 : rdata_q;
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected responses are queued at grant
// and popped whenever the arbiter raises an rvalid.
module tb_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_be;
  logic        m_ack;
  logic [31:0] m_rdata;
  logic        busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        is_d;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_be(d_be), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_be(m_be), .m_ack(m_ack),
    .m_rdata(m_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (i_rvalid || d_rvalid) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: i_rvalid=%0b d_rvalid=%0b, required none",
                 i_rvalid, d_rvalid);
      end else begin
        e = sb.pop_front();
        if ({i_rvalid, d_rvalid, (d_rvalid ? d_rdata : i_rdata)} !==
            {~e.is_d, e.is_d, e.data}) begin
          bad++;
          $display("FAIL sb_resp: got i=%0b d=%0b data=%h, required i=%0b d=%0b data=%h",
                   i_rvalid, d_rvalid, (d_rvalid ? d_rdata : i_rdata),
                   ~e.is_d, e.is_d, e.data);
        end
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    i_req = 1'b1; d_req = 1'b1;
    d_we = 1'b0; i_addr = 32'h0; d_addr = 32'h0;
    d_wdata = 32'h0; d_be = 4'h0; m_ack = 1'b0; m_rdata = 32'h0;
    @(negedge clk);
    total++;
    if ({i_gnt, d_gnt, i_rvalid, d_rvalid, m_req, m_we, busy} !== 7'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got %b, required 0000000",
               {i_gnt, d_gnt, i_rvalid, d_rvalid, m_req, m_we, busy});
    end
    total++;
    if ({i_rdata, d_rdata, m_addr, m_wdata, m_be} !== '0) begin
      bad++;
      $display("FAIL reset_data: got %h %h %h %h %h, required all 0",
               i_rdata, d_rdata, m_addr, m_wdata, m_be);
    end
    i_req = 1'b0; d_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_single_fetch();
    @(posedge clk); #1;
    i_req = 1'b1; i_addr = 32'h100;
    @(negedge clk);
    total++;
    if ({i_gnt, d_gnt, busy} !== 3'b100) begin
      bad++;
      $display("FAIL fetch_gnt: got gnt_i/d/busy=%b, required 100", {i_gnt, d_gnt, busy});
    end
    sb.push_back('{1'b0, 32'h00500093});
    @(posedge clk); #1;
    i_req = 1'b0; m_ack = 1'b1; m_rdata = 32'h00500093;
    @(negedge clk);
    total++;
    if ({m_req, m_we, m_be, m_addr, busy} !== {1'b1, 1'b0, 4'hf, 32'h100, 1'b1}) begin
      bad++;
      $display("FAIL fetch_mreq: got req=%b we=%b be=%h addr=%h busy=%b, required 1 0 f 00000100 1",
               m_req, m_we, m_be, m_addr, busy);
    end
    @(posedge clk); #1;
    m_ack = 1'b0; m_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    total++;
    if ({i_rvalid, m_req} !== 2'b10) begin
      bad++;
      $display("FAIL fetch_lat: got rvalid/m_req=%b, required 10", {i_rvalid, m_req});
    end
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if ({i_rvalid, busy} !== 2'b00) begin
      bad++;
      $display("FAIL fetch_done: got rvalid/busy=%b, required 00", {i_rvalid, busy});
    end
  endtask

  task automatic test_store();
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2004;
    d_wdata = 32'hDEADBEEF; d_be = 4'b0011;
    m_rdata = 32'h1234_5678;
    @(negedge clk);
    total++;
    if ({i_gnt, d_gnt} !== 2'b01) begin
      bad++;
      $display("FAIL store_gnt: got gnt_i/d=%b, required 01", {i_gnt, d_gnt});
    end
    sb.push_back('{1'b1, 32'h0});
    @(posedge clk); #1;
    d_req = 1'b0; d_wdata = 32'h0; d_addr = 32'h0; d_be = 4'h0;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) m_ack = 1'b1;
      @(negedge clk);
      total++;
      if ({m_req, m_we, m_addr, m_wdata, m_be, d_rvalid} !==
          {1'b1, 1'b1, 32'h2004, 32'hDEADBEEF, 4'b0011, 1'b0}) begin
        bad++;
        $display("FAIL store_hold%0d: got req=%b we=%b addr=%h wd=%h be=%b rv=%b, required 1 1 00002004 deadbeef 0011 0",
                 c, m_req, m_we, m_addr, m_wdata, m_be, d_rvalid);
      end
      @(posedge clk); #1;
    end
    m_ack = 1'b0;
    @(negedge clk);
    total++;
    if ({d_rvalid, d_rdata, m_req} !== {1'b1, 32'h0, 1'b0}) begin
      bad++;
      $display("FAIL store_resp: got rv=%b rdata=%h m_req=%b, required 1 00000000 0",
               d_rvalid, d_rdata, m_req);
    end
  endtask

  task automatic test_load();
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000;
    @(negedge clk);
    sb.push_back('{1'b1, 32'hCAFEF00D});
    @(posedge clk); #1;
    d_req = 1'b0;
    @(posedge clk); #1;
    m_ack = 1'b1; m_rdata = 32'hCAFEF00D;
    @(negedge clk);
    total++;
    if ({m_req, m_we, m_be, m_addr} !== {1'b1, 1'b0, 4'h0, 32'h3000}) begin
      bad++;
      $display("FAIL load_mreq: got req=%b we=%b be=%h addr=%h, required 1 0 0 00003000",
               m_req, m_we, m_be, m_addr);
    end
    @(posedge clk); #1;
    m_ack = 1'b0; m_rdata = 32'h0;
    @(posedge clk); #1;
  endtask

  task automatic test_collision();
    int   n;
    logic exp_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    n = 4;
`else
    n = 3;
`endif
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    i_addr = 32'h400; d_addr = 32'h800;
    for (int t = 0; t < n; t++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp_d = (t % 2 == 0);
`else
      exp_d = 1'b1;
`endif
      @(negedge clk);
      total++;
      if ({i_gnt, d_gnt, busy} !== {~exp_d, exp_d, 1'b0}) begin
        bad++;
        $display("FAIL coll_gnt%0d: got gnt_i/d/busy=%b, required %b",
                 t, {i_gnt, d_gnt, busy}, {~exp_d, exp_d, 1'b0});
      end
      sb.push_back('{exp_d, 32'hA000_0000 + t});
      @(posedge clk); #1;
      m_ack = 1'b1; m_rdata = 32'hA000_0000 + t;
      @(negedge clk);
      total++;
      if ({m_req, m_addr, i_gnt, d_gnt, busy} !==
          {1'b1, (exp_d ? 32'h800 : 32'h400), 2'b00, 1'b1}) begin
        bad++;
        $display("FAIL coll_busy%0d: got req=%b addr=%h gnt=%b busy=%b, required 1 %h 00 1",
                 t, m_req, m_addr, {i_gnt, d_gnt}, busy, (exp_d ? 32'h800 : 32'h400));
      end
      @(posedge clk); #1;
      m_ack = 1'b0; m_rdata = 32'hFFFF_FFFF;
      if (t == n - 1) begin
        i_req = 1'b0; d_req = 1'b0;
      end
      @(negedge clk);
      total++;
      if ({busy, i_gnt, d_gnt} !== 3'b100) begin
        bad++;
        $display("FAIL coll_resp%0d: got busy/gnt=%b, required 100", t, {busy, i_gnt, d_gnt});
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_abort();
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000;
    @(negedge clk);
    total++;
    if (d_gnt !== 1'b1) begin
      bad++;
      $display("FAIL abort_gnt: got d_gnt=%b, required 1", d_gnt);
    end
    @(posedge clk); #1;
    d_req = 1'b0;
    @(negedge clk);
    total++;
    if ({m_req, busy} !== 2'b11) begin
      bad++;
      $display("FAIL abort_busy: got m_req/busy=%b, required 11", {m_req, busy});
    end
    #2;
    reset = 1'b1;
    #1;
    total++;
    if ({m_req, busy, m_addr} !== {2'b00, 32'h0}) begin
      bad++;
      $display("FAIL abort_async: got m_req=%b busy=%b addr=%h, required 0 0 0",
               m_req, busy, m_addr);
    end
    @(posedge clk); #1;
    reset = 1'b0; m_ack = 1'b1; m_rdata = 32'h5555_5555;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if ({d_rvalid, i_rvalid, busy, m_req} !== 4'b0000) begin
        bad++;
        $display("FAIL abort_quiet%0d: got rv_d/rv_i/busy/m_req=%b, required 0000",
                 c, {d_rvalid, i_rvalid, busy, m_req});
      end
      @(posedge clk); #1;
      m_ack = 1'b0;
    end
  endtask

  task automatic test_idle_ack();
    @(posedge clk); #1;
    m_ack = 1'b1; m_rdata = 32'h7777_7777;
    @(posedge clk); #1;
    m_ack = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      total++;
      if ({i_rvalid, d_rvalid, busy, m_req} !== 4'b0000) begin
        bad++;
        $display("FAIL idle_ack%0d: got rv_i/rv_d/busy/m_req=%b, required 0000",
                 c, {i_rvalid, d_rvalid, busy, m_req});
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_store();
    test_load();
    test_collision();
    test_reset_abort();
    test_idle_ack();
    @(negedge clk);
    total++;
    if (sb.size() !== 0) begin
      bad++;
      $display("FAIL sb_drain: got %0d pending, required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
